// File: rtl/wb_reg_file.sv
// Write-back stage and architectural register file.
// Selects the write-back value, commits it to a 2**ADDR_W x DATA_W register
// file (register 0 hardwired to zero), serves two combinational read ports
// with same-cycle write-through bypass, and counts committed writes.
module wb_reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              regwrite_mem_wb,
  input  logic              MemtoReg_mem_wb,
  input  logic [DATA_W-1:0] read_data_mem_wb,
  input  logic [DATA_W-1:0] result_mem_wb,
  input  logic [ADDR_W-1:0] Reg_dest_op_mem_wb,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_we,
  output logic [CNT_W-1:0]  wr_count
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Storage for registers 1..DEPTH-1; register 0 has no flops.
  logic [DATA_W-1:0] mem_q [1:DEPTH-1];
  // Flat view of the file with index 0 tied to zero, so reads never need
  // to index outside the stored range.
  logic [DATA_W-1:0] file_s [DEPTH];

  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [DATA_W-1:0] wb_data_s;
  logic              wb_we_s;
  logic [DATA_W-1:0] rs_data_s;
  logic [DATA_W-1:0] rt_data_s;

  // Read-port resolution: zero register first, then bypass, then storage.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic              we,
    input logic [ADDR_W-1:0] dest,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] sdata
  );
    logic [DATA_W-1:0] r;
    if (addr == {ADDR_W{1'b0}}) begin
      r = {DATA_W{1'b0}};
    end else if (we && (addr == dest)) begin
      r = wdata;
    end else begin
      r = sdata;
    end
    return r;
  endfunction

  // Write-back mux and qualified write strobe; reset low kills the strobe
  // so neither storage nor bypass sees a write while in reset.
  always_comb begin
    wb_data_s = result_mem_wb;
    if (MemtoReg_mem_wb) begin
      wb_data_s = read_data_mem_wb;
    end else begin
      wb_data_s = result_mem_wb;
    end
    wb_we_s = regwrite_mem_wb && (Reg_dest_op_mem_wb != {ADDR_W{1'b0}}) && reset;
  end

  // Build the flat read view of the register file.
  always_comb begin
    file_s[0] = {DATA_W{1'b0}};
    for (int i = 1; i < DEPTH; i++) begin
      file_s[i] = mem_q[i];
    end
  end

  // Per-register storage with asynchronous clear and decoded write enable.
  for (genvar g = 1; g < DEPTH; g++) begin : g_reg
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        mem_q[g] <= {DATA_W{1'b0}};
      end else if (wb_we_s && (Reg_dest_op_mem_wb == ADDR_W'(g))) begin
        mem_q[g] <= wb_data_s;
      end else begin
        mem_q[g] <= mem_q[g];
      end
    end
  end

  // Next committed-write count; wraps silently at full scale.
  always_comb begin
    cnt_d = cnt_q;
    if (wb_we_s) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Committed-write counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Two independent combinational read ports.
  always_comb begin
    rs_data_s = read_port(rs_addr, wb_we_s, Reg_dest_op_mem_wb, wb_data_s, file_s[rs_addr]);
    rt_data_s = read_port(rt_addr, wb_we_s, Reg_dest_op_mem_wb, wb_data_s, file_s[rt_addr]);
  end

  assign rs_data  = rs_data_s;
  assign rt_data  = rt_data_s;
  assign wb_data  = wb_data_s;
  assign wb_we    = wb_we_s;
  assign wr_count = cnt_q;

endmodule
